// File: rtl/regfile_read_arbiter_if.sv
// Read-request / read-response handshake bundle for regfile_read_arbiter.
// Request side:  req_valid_i, req_addr_i (flattened, READERS*ADDR_W), req_ready_o.
// Response side: rsp_valid_o, rsp_ready_i, rsp_data_o, rsp_id_o, rsp_err_o.
// Signal suffixes are written from the arbiter's point of view.
// The slave modport is the arbiter. The master modport is the requesters plus the consumer.
interface regfile_read_arbiter_if #(
    parameter int unsigned READERS  = 2,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned ID_W     = 1
);
    logic [READERS-1:0]        req_valid_i;
    logic [READERS*ADDR_W-1:0] req_addr_i;
    logic [READERS-1:0]        req_ready_o;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [BITWIDTH-1:0]       rsp_data_o;
    logic [ID_W-1:0]           rsp_id_o;
    logic                      rsp_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin read arbiter in front of a flattened register array.
// Each accepted request is captured as a tagged response: data, requester id and an
// out-of-range error flag. A write in flight to the same register is forwarded
// (write-first). Responses leave through a 2-entry in-order output buffer.
// Ports:
//   clk        rising-edge clock
//   clk_en     qualifies every state update and handshake
//   async_rst  asynchronous reset, active-high
//   regs_i     flattened cell outputs; reg k = [k*BITWIDTH +: BITWIDTH]
//   wr_en_i / wr_addr_i / wr_data_i   write in flight to the cells this cycle
//   bus        request/response handshakes (slave modport)
// The one-hot grant req_ready_o is combinational from req_valid_i.
// All rsp_* outputs come straight from flops.
module regfile_read_arbiter #(
    parameter  int unsigned BITWIDTH  = 8,
    parameter  int unsigned REG_COUNT = 16,
    parameter  int unsigned READERS   = 2,
    localparam int unsigned ADDR_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
    localparam int unsigned ID_W      = (READERS > 1) ? $clog2(READERS) : 1
) (
    input  logic                          clk,
    input  logic                          clk_en,
    input  logic                          async_rst,
    input  logic [REG_COUNT*BITWIDTH-1:0] regs_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [BITWIDTH-1:0]           wr_data_i,
    regfile_read_arbiter_if.slave         bus
);

    typedef struct packed {
        logic                err;
        logic [ID_W-1:0]     id;
        logic [BITWIDTH-1:0] data;
    } rsp_t;

    // The buffer is two registered slots. head_q drives the outputs directly,
    // and tail_q holds the second entry.
    rsp_t             head_q;
    rsp_t             tail_q;
    logic             valid_q;
    logic [1:0]       count_q;
    logic [ID_W-1:0]  rr_q;

    logic             pop;
    logic             push;
    logic             space;
    logic [1:0]       count_next;
    logic [1:0]       wpos;
    logic [READERS-1:0] grant;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  rr_next;
    logic [ADDR_W-1:0]   sel_addr;
    logic [BITWIDTH-1:0] cell_data;
    logic             addr_err;
    rsp_t             new_rsp;

    // Handshake qualifiers and buffer bookkeeping.
    assign pop        = valid_q && bus.rsp_ready_i && clk_en;
    assign space      = (count_q < 2'd2) || pop;
    assign count_next = count_q + {1'b0, push} - {1'b0, pop};
    // After this cycle's pop, the slot index that the new entry lands in.
    assign wpos       = count_q - {1'b0, pop};

    // Round-robin scan from rr_q upward with wrap. First valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cand    = '0;
        push    = 1'b0;
        if (clk_en && space) begin
            for (int unsigned k = 0; k < READERS; k++) begin
                cand = ID_W'((32'(rr_q) + k) % READERS);
                if (!push && bus.req_valid_i[cand]) begin
                    grant[cand] = 1'b1;
                    gnt_idx     = cand;
                    push        = 1'b1;
                end
            end
        end
    end

    assign rr_next = (32'(gnt_idx) == READERS - 1) ? '0 : gnt_idx + 1'b1;

    // Pick the granted requester's address and read its register.
    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < READERS; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign addr_err = (32'(sel_addr) >= REG_COUNT);

    always_comb begin
        cell_data = '0;
        for (int unsigned k = 0; k < REG_COUNT; k++) begin
            if (sel_addr == ADDR_W'(k)) begin
                cell_data = regs_i[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Error forces data to zero. Otherwise a matching write in flight wins over the cell.
    always_comb begin
        new_rsp.err = addr_err;
        new_rsp.id  = gnt_idx;
        if (addr_err) begin
            new_rsp.data = '0;
        end else if (wr_en_i && clk_en && (wr_addr_i == sel_addr)) begin
            new_rsp.data = wr_data_i;
        end else begin
            new_rsp.data = cell_data;
        end
    end

    // Buffer, pointer and response-valid registers.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            count_q <= 2'd0;
            rr_q    <= '0;
        end else if (clk_en) begin
            count_q <= count_next;
            valid_q <= (count_next != 2'd0);
            if (push) begin
                rr_q <= rr_next;
            end
            // A pop from a full buffer moves the second entry forward.
            if (pop && (count_q == 2'd2)) begin
                head_q <= tail_q;
            end
            if (push) begin
                if (wpos == 2'd0) begin
                    head_q <= new_rsp;
                end else begin
                    tail_q <= new_rsp;
                end
            end
        end
    end

    assign bus.req_ready_o = grant;
    assign bus.rsp_valid_o = valid_q;
    assign bus.rsp_data_o  = head_q.data;
    assign bus.rsp_id_o    = head_q.id;
    assign bus.rsp_err_o   = head_q.err;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (REG_COUNT=10, READERS=2, BITWIDTH=8).
module tb_regfile_read_arbiter;

    localparam int unsigned BW  = 8;
    localparam int unsigned RC  = 10;
    localparam int unsigned RD  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned IW  = 1;

    logic            clk = 1'b0;
    logic            clk_en;
    logic            async_rst;
    logic [RC*BW-1:0] regs;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [BW-1:0]   wr_data;

    int tests = 0;
    int fails = 0;

    regfile_read_arbiter_if #(.READERS(RD), .ADDR_W(AW), .BITWIDTH(BW), .ID_W(IW)) bus ();

    regfile_read_arbiter #(.BITWIDTH(BW), .REG_COUNT(RC), .READERS(RD)) dut (
        .clk       (clk),
        .clk_en    (clk_en),
        .async_rst (async_rst),
        .regs_i    (regs),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.req_valid_i = v;
        bus.req_addr_i  = {a1, a0};
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d,
                           input logic id, input logic e);
        chk({tag, ".valid"}, 32'(bus.rsp_valid_o), 32'(v));
        chk({tag, ".data"},  32'(bus.rsp_data_o),  32'(d));
        chk({tag, ".id"},    32'(bus.rsp_id_o),    32'(id));
        chk({tag, ".err"},   32'(bus.rsp_err_o),   32'(e));
    endtask

    initial begin
        async_rst = 1'b1;
        clk_en    = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        bus.rsp_ready_i = 1'b0;
        req(2'b00, 4'd0, 4'd0);
        for (int k = 0; k < int'(RC); k++) regs[k*BW +: BW] = 8'(8'h20 + k);
        regs[3*BW +: BW] = 8'h5A;
        regs[7*BW +: BW] = 8'h11;

        // Reset state
        #2;
        chk_rsp("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset.ready", 32'(bus.req_ready_o), 32'h0);
        async_rst = 1'b0;

        // 1: single read, one-cycle latency
        bus.rsp_ready_i = 1'b1;
        req(2'b01, 4'd3, 4'd0);
        #1 chk("t1.ready", 32'(bus.req_ready_o), 32'h1);
        tick;
        chk_rsp("t1.rsp", 1'b1, 8'h5A, 1'b0, 1'b0);
        req(2'b00, 4'd0, 4'd0);
        tick;
        chk("t1.drain", 32'(bus.rsp_valid_o), 32'h0);

        // Reset between edges so round-robin starts at R0
        async_rst = 1'b1;
        #1 async_rst = 1'b0;

        // 2: both requesters valid, alternating grants
        req(2'b11, 4'd1, 4'd2);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2.ready", 32'(bus.req_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick;
            chk_rsp("t2.rsp", 1'b1, (k % 2 == 0) ? 8'h21 : 8'h22, 1'(k % 2), 1'b0);
        end
        req(2'b00, 4'd0, 4'd0);
        tick;
        chk("t2.drain", 32'(bus.rsp_valid_o), 32'h0);

        // 3: backpressure, buffer fills at two, third accepted on first pop
        bus.rsp_ready_i = 1'b0;
        req(2'b01, 4'd4, 4'd0);
        #1 chk("t3.ready_a", 32'(bus.req_ready_o), 32'h1);
        tick;
        req(2'b01, 4'd5, 4'd0);
        #1 chk("t3.ready_b", 32'(bus.req_ready_o), 32'h1);
        tick;
        req(2'b01, 4'd6, 4'd0);
        #1 chk("t3.ready_full", 32'(bus.req_ready_o), 32'h0);
        tick;
        chk_rsp("t3.hold", 1'b1, 8'h24, 1'b0, 1'b0);
        chk("t3.ready_still", 32'(bus.req_ready_o), 32'h0);
        bus.rsp_ready_i = 1'b1;
        #1 chk("t3.ready_pop", 32'(bus.req_ready_o), 32'h1);
        tick;
        chk_rsp("t3.second", 1'b1, 8'h25, 1'b0, 1'b0);
        req(2'b00, 4'd0, 4'd0);
        tick;
        chk_rsp("t3.third", 1'b1, 8'h26, 1'b0, 1'b0);
        tick;
        chk("t3.drain", 32'(bus.rsp_valid_o), 32'h0);

        // 4: write-first forwarding
        req(2'b01, 4'd7, 4'd0);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hC3;
        #1 chk("t4.ready", 32'(bus.req_ready_o), 32'h1);
        tick;
        wr_en = 1'b0;
        req(2'b00, 4'd0, 4'd0);
        chk_rsp("t4.fwd", 1'b1, 8'hC3, 1'b0, 1'b0);
        tick;
        chk("t4.drain", 32'(bus.rsp_valid_o), 32'h0);

        // 5a: out-of-range address
        req(2'b10, 4'd0, 4'd12);
        #1 chk("t5.ready_err", 32'(bus.req_ready_o), 32'h2);
        tick;
        chk_rsp("t5.err", 1'b1, 8'h00, 1'b1, 1'b1);
        req(2'b01, 4'd1, 4'd0);
        #1 chk("t5.ready_r0", 32'(bus.req_ready_o), 32'h1);
        tick;
        chk_rsp("t5.r0", 1'b1, 8'h21, 1'b0, 1'b0);

        // 5b: clk_en low for three cycles freezes everything
        clk_en = 1'b0;
        req(2'b11, 4'd2, 4'd3);
        #1 chk("t5.ready_off", 32'(bus.req_ready_o), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_rsp("t5.frozen", 1'b1, 8'h21, 1'b0, 1'b0);
            chk("t5.frozen_ready", 32'(bus.req_ready_o), 32'h0);
        end
        clk_en = 1'b1;
        #1 chk("t5.ready_on", 32'(bus.req_ready_o), 32'h2);
        tick;
        chk_rsp("t5.resume", 1'b1, 8'h5A, 1'b1, 1'b0);
        req(2'b00, 4'd0, 4'd0);
        tick;
        chk("t5.drain", 32'(bus.rsp_valid_o), 32'h0);

        // 6: async reset with two buffered entries
        bus.rsp_ready_i = 1'b0;
        req(2'b11, 4'd1, 4'd2);
        #1 chk("t6.ready_a", 32'(bus.req_ready_o), 32'h1);
        tick;
        #1 chk("t6.ready_b", 32'(bus.req_ready_o), 32'h2);
        tick;
        req(2'b00, 4'd0, 4'd0);
        chk_rsp("t6.full", 1'b1, 8'h21, 1'b0, 1'b0);
        #2 async_rst = 1'b1;
        #1 chk_rsp("t6.in_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        async_rst = 1'b0;
        bus.rsp_ready_i = 1'b1;
        req(2'b11, 4'd1, 4'd2);
        #1 chk("t6.rr_restart", 32'(bus.req_ready_o), 32'h1);
        tick;
        chk_rsp("t6.after", 1'b1, 8'h21, 1'b0, 1'b0);
        #1 chk("t6.next", 32'(bus.req_ready_o), 32'h2);
        req(2'b00, 4'd0, 4'd0);
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
